// File: rtl/md_sequencer.sv
// ============================================================================
// md_sequencer : multi-cycle MULT/DIV sequencer that owns HI/LO and drives busy
// Revision     : 1.0
// ============================================================================
`default_nettype none

module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] mf_data_o
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] pend_hi_q, pend_lo_q;
  logic [31:0] res_hi_d, res_lo_d;
  logic [3:0]  cnt_load_d;

  logic [63:0]        prod_u;
  logic signed [63:0] rs_sx, rt_sx, prod_s;
  logic               rs_neg, rt_neg;
  logic [31:0]        a_mag, b_mag, divisor, q_mag, r_mag, quo, rem;

  assign prod_u = {32'b0, rs_data_i} * {32'b0, rt_data_i};
  assign rs_sx  = {{32{rs_data_i[31]}}, rs_data_i};
  assign rt_sx  = {{32{rt_data_i[31]}}, rt_data_i};
  assign prod_s = rs_sx * rt_sx;

  // Signed divide via magnitudes so 0x80000000 / -1 yields 0x80000000 rem 0.
  assign rs_neg  = (op_i == 3'd2) && rs_data_i[31];
  assign rt_neg  = (op_i == 3'd2) && rt_data_i[31];
  assign a_mag   = rs_neg ? (~rs_data_i + 32'd1) : rs_data_i;
  assign b_mag   = rt_neg ? (~rt_data_i + 32'd1) : rt_data_i;
  assign divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag   = a_mag / divisor;
  assign r_mag   = a_mag % divisor;
  assign quo     = (rs_neg ^ rt_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem     = rs_neg ? (~r_mag + 32'd1) : r_mag;

  assign cnt_load_d = op_i[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);

  always_comb begin
    res_hi_d = hi_q;
    res_lo_d = lo_q;
    case (op_i)
      3'd0: {res_hi_d, res_lo_d} = prod_s;
      3'd1: {res_hi_d, res_lo_d} = prod_u;
      3'd2, 3'd3: begin
        // Divide by zero keeps HI/LO; they cannot change while busy.
        if (rt_data_i != 32'd0) begin
          res_hi_d = rem;
          res_lo_d = quo;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      busy_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (!op_i[2]) begin
              pend_hi_q <= res_hi_d;
              pend_lo_q <= res_lo_d;
              cnt_q     <= cnt_load_d;
              busy_q    <= 1'b1;
              state_q   <= RUN;
            end else if (op_i == 3'd4) begin
              hi_q <= rs_data_i;
            end else if (op_i == 3'd5) begin
              lo_q <= rs_data_i;
            end
          end
        end
        RUN: begin
          if (cnt_q == 4'd1) begin
            hi_q    <= pend_hi_q;
            lo_q    <= pend_lo_q;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;
  assign mf_data_o = (op_i == 3'd7) ? lo_q : hi_q;

endmodule

`default_nettype wire
